word_descrambler16: RTL and testbench
=====================================

# word_descrambler16

16-bit additive stream descrambler: the receive-side inverse of the datapath's XOR-with-keystream scrambler. It accepts scrambled 16-bit words over a valid/ready handshake and XORs each word with a keystream word from a 16-bit Fibonacci LFSR. It emits the recovered plaintext through a one-entry registered output stage. It sits between the serial link deframer and the CPU-side input buffer.

## Interface
- `SEED`, default 16'hACE1: LFSR load value on resync; must be nonzero.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `resync`  in  1  one-cycle pulse; loads `SEED` and enters SYNC.
- `in_data`  in  16  scrambled word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `out_data`  out  16  descrambled word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `synced`  out  1  high while the FSM is in SYNC.
- `word_count`  out  16  words emitted since the last resync; wraps 16'hFFFF→0.

## Operation
- LFSR state `s[15:0]`.
  - Single step: `fb = s[15]^s[13]^s[12]^s[10]`; `s <= {s[14:0], fb}`.
  - Advancing one word means 16 single steps, computed combinationally within one cycle.
- Keystream word is the current `s`. Descrambled word = `in_data ^ s`, applied bitwise across all 16 bits.
- Accept condition: `in_valid && in_ready`.
- FSM states:
  - UNSYNC: `in_ready = 1`. Accepted words are discarded (no output, LFSR holds). Goes to SYNC on `resync`.
  - SYNC: `in_ready = !out_valid || out_ready`. Each accepted word loads the output register and advances the LFSR by one word. Stays in SYNC; `resync` re-seeds.
- `resync` in any state:
  - `s` takes `SEED` and `word_count` is cleared.
  - If a word is accepted in the same cycle, it is descrambled with `SEED` and is the first word of the new stream. `s` becomes adv16(`SEED`) and `word_count` becomes 1 when that word is emitted.
- `word_count` increments on each accepted word in SYNC. It counts loads into the output register, not downstream transfers.
- Output register: `out_valid` sets on accept in SYNC. It clears when `out_ready && out_valid` and no new accept occurs that cycle.
- `resync` does not flush a pending output word; that word keeps its original contents.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `synced = 0`, `word_count = 0`, `s = SEED`, state UNSYNC. `in_ready = 1` during the cycle after reset deasserts.
- `reset` takes precedence over `resync` and over any handshake in the same cycle.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid = 1` after edge N.
- Throughput: one word per cycle when `out_ready` is held high.
- Back-pressure: while `out_valid && !out_ready`, `in_ready = 0`, and `out_data`, `s` and `word_count` hold.
- Simultaneous output drain and input accept: the new word replaces the old one with no bubble.
- Reset mid-stream drops the pending word: `out_valid` falls at the next edge.
- `in_ready` is combinational from `out_ready` and state only; it never depends on `in_valid`.

## Structure
- Shared package `descrambler_pkg` holds:
  - the tap constants (15, 13, 12, 10);
  - `SEED_DEFAULT = 16'hACE1`;
  - the FSM enum {UNSYNC, SYNC};
  - a function `lfsr16_step(s)`.
- Sub-module `lfsr16_adv16`: purely combinational; input `s`, output `s` after 16 steps. It is shared with the transmit-side scrambler, so both ends stay consistent by construction.
- The XOR is a plain bitwise 16-bit XOR. The top level holds the FSM, the LFSR register, the output register and the counter.

## Test plan
- Reset, then `in_valid = 1`, `in_data = 16'h1234` for 3 cycles with no resync → no `out_valid`; `synced = 0`; `s` still 16'hACE1.
- Pulse `resync` alone, then send 16'h0000 → `out_data = 16'hACE1`; `word_count = 1`. Send 16'hACE1 next → output equals adv16(16'hACE1) XOR 16'hACE1 per the golden model.
- `resync` in the same cycle as accepting 16'hFFFF → `out_data = 16'h531E`, i.e. 16'hFFFF ^ `SEED`.
- Hold `out_ready = 0` for 5 cycles with `in_valid = 1` → `in_ready = 0`; `out_data`, `word_count` and `s` are stable. Release → one word per cycle follows, with no loss or duplication against the golden model.
- Round trip: scramble 1000 random words with the reference model, descramble them with random `in_valid`/`out_ready` → every output matches its plaintext; `word_count = 1000`.
- Force `word_count` to 16'hFFFF via 65535 accepts, then accept one more → `word_count` wraps to 0. Separately, assert `reset` while `out_valid = 1` → `out_valid = 0` and `synced = 0` the next cycle.

Source files
------------

// File: rtl/descrambler_pkg.sv
// Shared definitions for the 16-bit additive scrambler/descrambler pair:
// LFSR taps, default seed, FSM states and the single-step LFSR function.
package descrambler_pkg;

  localparam int TAP0 = 15;
  localparam int TAP1 = 13;
  localparam int TAP2 = 12;
  localparam int TAP3 = 10;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic {
    UNSYNC,
    SYNC
  } state_t;

  // One Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    logic fb;
    fb = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
    return {s[14:0], fb};
  endfunction

endpackage

// File: rtl/lfsr16_adv16.sv
// Combinational 16-step advance of the keystream LFSR; shared with the
// transmit-side scrambler so both ends derive the same keystream.
module lfsr16_adv16
  import descrambler_pkg::*;
(
  input  logic [15:0] s,
  output logic [15:0] s_adv
);

  // NOTE: blocking assignments here are intentional; each iteration must see
  // the previous one's result within the same evaluation.
  always_comb begin
    s_adv = s;
    for (int i = 0; i < 16; i++) begin
      s_adv = lfsr16_step(s_adv);
    end
  end

endmodule

// File: rtl/word_descrambler16.sv
// Receive-side word descrambler: XORs accepted words with the LFSR keystream
// and presents plaintext through a one-entry registered output stage.
module word_descrambler16
  import descrambler_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        resync,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        synced,
  output logic [15:0] word_count
);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] key;
  logic [15:0] key_adv;
  logic        accept;
  logic        load;

  // A resync in the same cycle as an accept makes that word the first of the
  // new stream, so the seed is used directly as its keystream word.
  assign key = resync ? SEED : lfsr;

  lfsr16_adv16 u_adv (
    .s     (key),
    .s_adv (key_adv)
  );

  assign in_ready = (state == UNSYNC) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && ((state == SYNC) || resync);
  assign synced   = (state == SYNC);

  // NOTE: non-blocking assignments for all sequential state so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNSYNC;
      lfsr       <= SEED;
      out_data   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      if (resync) begin
        state      <= SYNC;
        lfsr       <= SEED;
        word_count <= '0;
      end
      if (load) begin
        out_data   <= in_data ^ key;
        out_valid  <= 1'b1;
        lfsr       <= key_adv;
        word_count <= resync ? 16'd1 : word_count + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_descrambler16.sv
// Self-checking bench for word_descrambler16: a word-level reference model
// checked every cycle, directed corner cases and a randomized round trip.
module tb_word_descrambler16;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        resync = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        synced;
  logic [15:0] word_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  word_descrambler16 #(.SEED(SEED)) dut (
    .clk        (clk),
    .reset      (reset),
    .resync     (resync),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .synced     (synced),
    .word_count (word_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Keystream advance: the feedback bit is the parity of the tapped bits
  // (mask 0xB400 = bits 15,13,12,10), applied sixteen times per word.
  function automatic logic [15:0] ks_next(input logic [15:0] k);
    logic [15:0] r;
    r = k;
    repeat (16) r = {r[14:0], ^(r & 16'hB400)};
    return r;
  endfunction

  // Word-level reference model, updated on every rising edge.
  logic        m_sync  = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_data  = '0;
  logic [15:0] m_count = '0;
  logic [15:0] m_key   = SEED;
  logic        m_acc   = 1'b0;
  logic        cmp_en  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_sync  = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_count = '0;
      m_key   = SEED;
      m_acc   = 1'b0;
    end else begin
      m_acc = in_valid && !(m_valid && !out_ready);
      if (resync) begin
        m_sync  = 1'b1;
        m_key   = SEED;
        m_count = '0;
      end
      if (m_acc && m_sync) begin
        m_data  = in_data ^ m_key;
        m_valid = 1'b1;
        m_key   = ks_next(m_key);
        m_count = m_count + 16'd1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Round-trip scoreboard: plaintexts in the order they must leave the DUT.
  logic [15:0] rt_q[$];
  logic        rt_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",   in_ready,   !(m_valid && !out_ready));
      check("out_valid",  out_valid,  m_valid);
      check("out_data",   out_data,   m_data);
      check("word_count", word_count, m_count);
      check("synced",     synced,     m_sync);
    end
    if (rt_en && out_valid && out_ready) begin
      if (rt_q.size() == 0) check("rt_extra_word", 1, 0);
      else check("rt_plaintext", out_data, rt_q.pop_front());
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pt[1000];
    logic [15:0] sc[1000];
    logic [15:0] ks;
    int          idx;
    int          budget;

    reset = 1'b1;
    cycle();
    cycle();
    cmp_en = 1'b1;
    reset  = 1'b0;
    check("reset_out_valid",  out_valid,  0);
    check("reset_out_data",   out_data,   0);
    check("reset_word_count", word_count, 0);
    check("reset_synced",     synced,     0);
    check("reset_in_ready",   in_ready,   1);

    // Unsynchronised: words are accepted and dropped.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    repeat (3) cycle();
    check("unsync_no_out", out_valid, 0);
    check("unsync_synced", synced, 0);

    // Resync alone, then two words: keystream SEED then adv16(SEED).
    in_valid = 1'b0;
    resync   = 1'b1;
    cycle();
    resync   = 1'b0;
    check("resync_synced", synced, 1);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    cycle();
    check("first_word", out_data, 16'hACE1);
    check("first_count", word_count, 1);
    in_data = 16'hACE1;
    cycle();
    check("second_word", out_data, ks_next(16'hACE1) ^ 16'hACE1);
    check("second_count", word_count, 2);

    // Resync coinciding with an accept: the word uses SEED itself.
    resync  = 1'b1;
    in_data = 16'hFFFF;
    cycle();
    resync = 1'b0;
    check("resync_accept_word", out_data, 16'h531E);
    check("resync_accept_count", word_count, 1);

    // Back-pressure for 5 cycles, then release at full rate.
    out_ready = 1'b0;
    repeat (5) begin
      in_data = 16'($urandom);
      cycle();
    end
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_data", out_data, 16'h531E);
    check("bp_hold_count", word_count, 1);
    out_ready = 1'b1;
    repeat (5) begin
      in_data = 16'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("bp_release_count", word_count, 6);

    // Round trip: scramble 1000 words with the model keystream, random flow.
    resync = 1'b1;
    cycle();
    resync = 1'b0;
    ks = SEED;
    for (int i = 0; i < 1000; i++) begin
      pt[i] = 16'($urandom);
      sc[i] = pt[i] ^ ks;
      ks    = ks_next(ks);
      rt_q.push_back(pt[i]);
    end
    rt_en  = 1'b1;
    idx    = 0;
    budget = 0;
    while (idx < 1000 && budget < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = sc[idx];
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (m_acc) idx++;
      budget++;
    end
    check("rt_all_sent", idx, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
    rt_en = 1'b0;
    check("rt_queue_empty", rt_q.size(), 0);
    check("rt_word_count", word_count, 1000);

    // Counter wrap after 65536 accepts.
    resync = 1'b1;
    cycle();
    resync   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 16'($urandom);
      cycle();
    end
    check("count_ffff", word_count, 16'hFFFF);
    cycle();
    check("count_wrap", word_count, 0);

    // Reset with a pending word drops it.
    out_ready = 1'b0;
    cycle();
    check("pending_before_reset", out_valid, 1);
    in_valid = 1'b0;
    reset    = 1'b1;
    cycle();
    check("reset_drops_word", out_valid, 0);
    check("reset_clears_sync", synced, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
